// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Default display word width (8 hex digits).
  localparam int DEF_DATA_W = 32;

  // Value driven on the display data bus out of reset.
  localparam logic [DEF_DATA_W-1:0] RST_DATA = '0;

  // Width of a requester index, never less than one bit.
  function automatic int idx_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  // Reset value of the round-robin pointer: the last requester, so that
  // the first search starts at requester 0.
  function automatic int rst_ptr(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/seg_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found searching upward from (ptr + 1) mod NUM_REQ, with wrap-around.
module seg_arb_rr_pick
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display driver
// between NUM_REQ requesters. Each grant produces a one-cycle write strobe
// and ack, then holds the display for HOLD_CYCLES cycles.
// Optional build macro SEG_ARB_PRIO0_EN: requester 0 becomes a preemptive
// priority source that always wins in IDLE and can abort another
// requester's hold.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 50000000,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        disp_we,
  output logic [DATA_W-1:0]           disp_wdata,
  output logic [idx_w(NUM_REQ)-1:0]   owner,
  output logic                        busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CW    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0]   RST_PTR  = IDX_W'(rst_ptr(NUM_REQ));
  localparam logic [CW-1:0]      CNT_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CW-1:0]     cnt_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              start;
  logic [IDX_W-1:0]  grant_idx;

  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Unflatten the requester data bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  seg_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state logic and grant decision.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    grant_idx = pick_idx;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_WRITE;
          start   = 1'b1;
`ifdef SEG_ARB_PRIO0_EN
          if (req[0]) grant_idx = '0;
`endif
        end
      end
      ST_WRITE: begin
        state_d = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
`ifdef SEG_ARB_PRIO0_EN
        // The CPU preempts a hold owned by any other requester.
        if (req[0] && (owner != '0)) begin
          state_d   = ST_WRITE;
          start     = 1'b1;
          grant_idx = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= RST_PTR;
      idx_q      <= '0;
      cnt_q      <= '0;
      ack        <= '0;
      disp_we    <= 1'b0;
      disp_wdata <= DATA_W'(RST_DATA);
      owner      <= '0;
      busy       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      ack     <= '0;
      disp_we <= 1'b0;
      if (start) begin
        // Data is captured at the decision edge; later req_data changes
        // cannot disturb the pending write.
        idx_q      <= grant_idx;
        ack        <= ONE_HOT0 << grant_idx;
        disp_we    <= 1'b1;
        disp_wdata <= data_arr[grant_idx];
      end
      if (state_q == ST_WRITE) begin
        ptr_q <= idx_q;
        owner <= idx_q;
        cnt_q <= '0;
      end else if (state_q == ST_HOLD) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: a vector table for the
// round-robin rotation plus hand-written multi-cycle sequences.
module tb_seg_display_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with a 4-cycle hold.
  logic [2:0]  req4;
  logic [95:0] data4;
  logic [2:0]  ack4;
  logic        we4;
  logic [31:0] wdata4;
  logic [1:0]  owner4;
  logic        busy4;

  // DUT with no hold.
  logic [2:0]  req0;
  logic [95:0] data0;
  logic [2:0]  ack0;
  logic        we0;
  logic [31:0] wdata0;
  logic [1:0]  owner0;
  logic        busy0;

  // DUT with a 100-cycle hold.
  logic [2:0]  req100;
  logic [95:0] data100;
  logic [2:0]  ack100;
  logic        we100;
  logic [31:0] wdata100;
  logic [1:0]  owner100;
  logic        busy100;

  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .req_data(data4), .ack(ack4),
    .disp_we(we4), .disp_wdata(wdata4), .owner(owner4), .busy(busy4)
  );

  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(0), .DATA_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_data(data0), .ack(ack0),
    .disp_we(we0), .disp_wdata(wdata0), .owner(owner0), .busy(busy0)
  );

  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(100), .DATA_W(32)) dut100 (
    .clk(clk), .rst_n(rst_n), .req(req100), .req_data(data100), .ack(ack100),
    .disp_we(we100), .disp_wdata(wdata100), .owner(owner100), .busy(busy100)
  );

  typedef struct {
    logic [2:0]  req;
    logic        exp_we;
    logic [2:0]  exp_ack;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_owner;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [19];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dv [3];
    int waited;

    dv[0] = 32'h11111111;
    dv[1] = 32'h22222222;
    dv[2] = 32'h33333333;

    // Rotation with all three requesting and a 4-cycle hold: one grant
    // every 6 cycles, order 0,1,2,0. Cycle phase 0 = WRITE, 1..4 = HOLD,
    // 5 = IDLE. Owner reflects the previous grant during a WRITE cycle.
    for (int s = 0; s < 19; s++) begin
      int g;
      int pos;
      g   = (s / 6) % 3;
      pos = s % 6;
      vecs[s].req       = 3'b111;
      vecs[s].exp_we    = (pos == 0);
      vecs[s].exp_ack   = (pos == 0) ? 3'(1 << g) : 3'b000;
      vecs[s].exp_wdata = dv[g];
      vecs[s].exp_owner = (s == 0) ? 2'd0 : (pos == 0) ? 2'((g + 2) % 3) : 2'(g);
      vecs[s].exp_busy  = (pos != 5);
    end

    rst_n   = 1'b0;
    req4    = '0;
    req0    = '0;
    req100  = '0;
    data4   = {dv[2], dv[1], dv[0]};
    data0   = '0;
    data100 = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_we",    we4,    0);
    check("rst_ack",   ack4,   0);
    check("rst_wdata", wdata4, 0);
    check("rst_owner", owner4, 0);
    check("rst_busy",  busy4,  0);
    rst_n = 1'b1;

    // Round-robin rotation table.
    for (int i = 0; i < 19; i++) begin
      req4 = vecs[i].req;
      tick();
      check($sformatf("rr%0d_we", i),    we4,    vecs[i].exp_we);
      check($sformatf("rr%0d_ack", i),   ack4,   vecs[i].exp_ack);
      check($sformatf("rr%0d_wdata", i), wdata4, vecs[i].exp_wdata);
      check($sformatf("rr%0d_owner", i), owner4, vecs[i].exp_owner);
      check($sformatf("rr%0d_busy", i),  busy4,  vecs[i].exp_busy);
    end

    // Single request from requester 2; busy spans WRITE plus 4 HOLD cycles.
    req4 = '0;
    repeat (5) tick();
    check("t2_idle", busy4, 0);
    data4[95:64] = 32'hDEADBEEF;
    req4 = 3'b100;
    tick();
    check("t2_we",    we4,    1);
    check("t2_wdata", wdata4, 32'hDEADBEEF);
    check("t2_ack",   ack4,   3'b100);
    check("t2_busy1", busy4,  1);
    req4 = '0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("t2_busy%0d", k), busy4, 1);
      check($sformatf("t2_we%0d", k),   we4,   0);
    end
    tick();
    check("t2_busy6", busy4,  0);
    check("t2_owner", owner4, 2);

    // Data captured at the decision edge, not during WRITE.
    data4[31:0] = 32'hAAAA0000;
    req4 = 3'b001;
    tick();
    data4[31:0] = 32'hBBBB0000;
    req4 = '0;
    check("t5_ack",    ack4,   3'b001);
    check("t5_wdata",  wdata4, 32'hAAAA0000);
    tick();
    check("t5_wdata_hold", wdata4, 32'hAAAA0000);

    // No hold: requester 1 held high writes every other cycle.
    data0[63:32] = 32'h5A5A5A5A;
    req0 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t3_we%0d", i),   we0,   (i % 2 == 0));
      check($sformatf("t3_ack%0d", i),  ack0,  (i % 2 == 0) ? 3'b010 : 3'b000);
      check($sformatf("t3_busy%0d", i), busy0, (i % 2 == 0));
      if (i > 0) check($sformatf("t3_owner%0d", i), owner0, 1);
    end
    check("t3_wdata", wdata0, 32'h5A5A5A5A);
    req0 = '0;

    // Requester 0 arriving mid-hold of requester 2 (100-cycle hold).
    data100[95:64] = 32'h22220000;
    req100 = 3'b100;
    tick();
    check("t6_ack2", ack100, 3'b100);
    req100 = '0;
    tick();
    check("t6_owner", owner100, 2);
    repeat (10) tick();
    data100[31:0] = 32'h0C0C0C0C;
    req100 = 3'b001;
`ifdef SEG_ARB_PRIO0_EN
    tick();
    check("t6_we",    we100,    1);
    check("t6_ack0",  ack100,   3'b001);
    check("t6_wdata", wdata100, 32'h0C0C0C0C);
`else
    // Remaining hold counts 10..99 (90 cycles), one IDLE, then WRITE.
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!we100 && waited < 200);
    check("t6_wait",  waited,   91);
    check("t6_ack0",  ack100,   3'b001);
    check("t6_wdata", wdata100, 32'h0C0C0C0C);
`endif
    req100 = '0;

    // Reset mid-HOLD after a grant to requester 1.
    waited = 0;
    while (busy4 && waited < 20) begin
      tick();
      waited++;
    end
    check("t4_idle", busy4, 0);
    data4[63:32] = 32'h44444444;
    req4 = 3'b010;
    tick();
    check("t4_ack1", ack4, 3'b010);
    req4 = '0;
    repeat (2) tick();
    check("t4_owner1", owner4, 1);
    check("t4_busy",   busy4,  1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_we",    we4,    0);
    check("t4_rst_ack",   ack4,   0);
    check("t4_rst_wdata", wdata4, 0);
    check("t4_rst_busy",  busy4,  0);
    check("t4_rst_owner", owner4, 0);
    tick();
    rst_n = 1'b1;
    req4 = 3'b011;
    tick();
    check("t4_post_ack",   ack4,   3'b001);
    check("t4_post_wdata", wdata4, 32'hBBBB0000);
    req4 = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the single 8-digit seven-segment display driver between NUM_REQ requesters, for example CPU MMIO stores, a debug PC monitor and a switch echo.
- Round-robin arbitration with a req/ack handshake.
- Emits a one-cycle write strobe plus 32-bit data toward the display driver's we/wdata inputs.
- After each write, the winner keeps the display for a minimum number of cycles so values stay readable.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
HOLD_CYCLES, 50000000, cycles the display is held after a write before re-arbitration (1 s at 50 MHz); 0 is legal
DATA_W, 32, display word width (8 hex digits)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; level, held until ack
req_data  input  NUM_REQ*DATA_W  flattened data; requester i occupies bits [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester
disp_we  output  1  one-cycle write strobe to the display driver
disp_wdata  output  DATA_W  data written; valid when disp_we=1, holds its last value otherwise
owner  output  max(1,$clog2(NUM_REQ))  index of the last granted requester
busy  output  1  high in WRITE and HOLD

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ack=0, disp_we=0, disp_wdata=0, busy=0.
  - owner=0; internal rr pointer=NUM_REQ-1, so requester 0 wins first; hold counter=0.
  - Reset mid-WRITE or mid-HOLD aborts immediately. No ack or strobe is issued for the aborted grant.
- States: IDLE, WRITE, HOLD.
- IDLE:
  - If req!=0, pick the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - Latch that requester's index and data, then go to WRITE.
  - If req=0, stay in IDLE.
- WRITE (exactly one cycle):
  - disp_we=1, disp_wdata=latched data, ack[idx]=1.
  - ptr<=idx, owner<=idx, counter<=0.
  - Next state is HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD:
  - Counter increments each cycle. Leave to IDLE in the cycle the counter equals HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles in HOLD.
  - Requests are not sampled; they stay pending.
- Latency: req sampled in IDLE cycle N -> disp_we/ack in cycle N+1. The minimum grant-to-grant spacing is HOLD_CYCLES+2 cycles.
- Data is captured at the IDLE decision edge. Later changes to req_data do not affect the pending write.
- Dropped request: if a requester drops req before being picked, it is ignored with no error.
- Ack timing: the requester must deassert req in the cycle after ack. If req is still high in the next IDLE, it is treated as a new request.
- Fairness: with all requesters requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0,...
- Counter width: $clog2(HOLD_CYCLES+1), minimum 1.
- Outputs are registered; ack and disp_we are asserted in the same cycle.

Optional Feature:
Macro SEG_ARB_PRIO0_EN.
- Defined:
  - Requester 0 is a preemptive priority source (the CPU).
  - In IDLE, req[0]=1 always wins, whatever the pointer.
  - In HOLD with owner!=0, req[0]=1 aborts the hold: the next cycle is WRITE for requester 0.
  - The pointer is updated to 0 after any requester-0 grant.
- Undefined: requester 0 is an ordinary round-robin participant and HOLD is never aborted.

Decomposition:
- Package seg_arb_pkg:
  - state enum (IDLE, WRITE, HOLD);
  - DATA_W default;
  - reset constants RST_PTR and RST_DATA (=0).
- Sub-module seg_arb_rr_pick: a combinational round-robin picker.
  - Inputs: req and ptr.
  - Outputs: a valid flag and the chosen index.
  - Instantiated once; under SEG_ARB_PRIO0_EN the req[0] override is applied outside it.

Test Plan:
- Reset then req=3'b111 (HOLD_CYCLES=4, data 0x11111111/0x22222222/0x33333333): grants in order 0,1,2,0, each disp_we carrying matching data; grant spacing is exactly 6 cycles.
- Single req[2] with data 0xDEADBEEF in IDLE at cycle N: disp_we=1, disp_wdata=0xDEADBEEF, ack=3'b100 at N+1; busy high for cycles N+1..N+5.
- HOLD_CYCLES=0, req[1] held continuously: writes occur every 2 cycles (WRITE, IDLE alternating); owner=1 throughout.
- rst_n pulled low during HOLD after a grant to requester 1: outputs are 0 immediately; after release, req=3'b011 grants requester 0 first.
- req_data[0] changes from 0xAAAA0000 to 0xBBBB0000 in the WRITE cycle: disp_wdata=0xAAAA0000.
- SEG_ARB_PRIO0_EN defined, owner=2 in HOLD (HOLD_CYCLES=100), req[0] asserted at hold count 10: WRITE for requester 0 in the next cycle. Without the macro, the grant occurs only after the full hold.
